// File: rtl/alu_types.sv
// rtl/alu_types.sv - ALU opcode type shared by the arbiter, its requesters and the ALU
package alu_types;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } operation_t;

endpackage

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU among NREQ requesters with in-order result steering
// Define ALU_ARB_PRIO_EN to give requester 0 fixed highest priority over the round-robin group.
module alu_arbiter #(
  parameter int WIDTH   = 6,
  parameter int NREQ    = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  alu_types::operation_t [NREQ-1:0] req_op,
  input  logic [NREQ-1:0][WIDTH-1:0]       req_a,
  input  logic [NREQ-1:0][WIDTH-1:0]       req_b,
  output logic [NREQ-1:0]                  rsp_valid,
  output logic [WIDTH:0]                   rsp_data,
  output alu_types::operation_t            alu_op_in,
  output logic [WIDTH-1:0]                 alu_a_in,
  output logic [WIDTH-1:0]                 alu_b_in,
  output logic                             alu_in_valid,
  input  logic [WIDTH:0]                   alu_out,
  input  logic                             alu_out_valid,
  output logic [$clog2(MAX_OUT):0]         outstanding,
  output logic                             err_orphan
);

  localparam int PW = $clog2(NREQ);
  localparam int AW = $clog2(MAX_OUT);
  localparam logic [AW:0] MAX_CNT = MAX_OUT[AW:0];

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] cand;
  logic          grant;
  logic          prio_hit;
  logic          slot_free;
  logic          pop;
  logic [PW-1:0] tag_mem [MAX_OUT];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [PW-1:0] head_tag;

  // A retiring result frees its slot in the same cycle, so a full FIFO can still issue.
  assign slot_free = (outstanding < MAX_CNT) || alu_out_valid;
  assign pop       = alu_out_valid && (outstanding != '0);
  assign head_tag  = tag_mem[rd_ptr];

  always_comb begin
    grant     = 1'b0;
    prio_hit  = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (rst && slot_free) begin
`ifdef ALU_ARB_PRIO_EN
      if (req_valid[0]) begin
        grant    = 1'b1;
        prio_hit = 1'b1;
      end
`endif
      for (int k = 0; k < NREQ; k++) begin
        cand = PW'((int'(rr_ptr) + k) % NREQ);
        if (!grant && req_valid[cand]) begin
          grant     = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr       <= '0;
      alu_in_valid <= 1'b0;
      alu_op_in    <= alu_types::OP_ADD;
      alu_a_in     <= '0;
      alu_b_in     <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      outstanding  <= '0;
      err_orphan   <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      alu_in_valid <= grant;
      if (grant) begin
        alu_op_in <= req_op[grant_idx];
        alu_a_in  <= req_a[grant_idx];
        alu_b_in  <= req_b[grant_idx];
        wr_ptr    <= wr_ptr + 1'b1;
        if (!prio_hit) rr_ptr <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end

      rsp_valid <= '0;
      if (pop) begin
        rsp_valid[head_tag] <= 1'b1;
        rsp_data            <= alu_out;
        rd_ptr              <= rd_ptr + 1'b1;
      end
      if (alu_out_valid && (outstanding == '0)) err_orphan <= 1'b1;

      if (grant && !pop) begin
        outstanding <= outstanding + 1'b1;
      end else if (!grant && pop) begin
        outstanding <= outstanding - 1'b1;
      end
    end
  end

  // Tag storage needs no reset: entries are only read below the valid count.
  always_ff @(posedge clk) begin
    if (grant) tag_mem[wr_ptr] <= grant_idx;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a variable-latency ALU model
module tb_alu_arbiter;
  import alu_types::*;

  localparam int WIDTH   = 6;
  localparam int NREQ    = 4;
  localparam int MAX_OUT = 4;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  operation_t [NREQ-1:0]      req_op;
  logic [NREQ-1:0][WIDTH-1:0] req_a;
  logic [NREQ-1:0][WIDTH-1:0] req_b;
  logic [NREQ-1:0]            rsp_valid;
  logic [WIDTH:0]             rsp_data;
  operation_t                 alu_op_in;
  logic [WIDTH-1:0]           alu_a_in;
  logic [WIDTH-1:0]           alu_b_in;
  logic                       alu_in_valid;
  logic [WIDTH:0]             alu_out;
  logic                       alu_out_valid;
  logic [2:0]                 outstanding;
  logic                       err_orphan;

  logic           model_valid = 1'b0;
  logic [WIDTH:0] model_data  = '0;
  logic           inj_valid   = 1'b0;
  logic [WIDTH:0] inj_data    = '0;
  int             alu_lat     = 2;
  int             cyc         = 0;
  int             q_due[$];
  logic [WIDTH:0] q_res[$];
  int             checks;
  int             failures;
  logic [3:0]     fexp;

  assign alu_out_valid = model_valid | inj_valid;
  assign alu_out       = inj_valid ? inj_data : model_data;

  alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .alu_op_in(alu_op_in), .alu_a_in(alu_a_in), .alu_b_in(alu_b_in),
    .alu_in_valid(alu_in_valid), .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] alu_f(input operation_t op, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      OP_AND:  return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  // ALU stand-in: each negedge is one cycle; a result comes back alu_lat cycles after issue.
  always @(negedge clk) begin
    if (!rst) begin
      q_due.delete();
      q_res.delete();
      model_valid = 1'b0;
      cyc = 0;
    end else begin
      cyc++;
      model_valid = 1'b0;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
        model_valid = 1'b1;
        model_data  = q_res.pop_front();
        void'(q_due.pop_front());
      end
      if (alu_in_valid) begin
        q_due.push_back(cyc + alu_lat);
        q_res.push_back(alu_f(alu_op_in, alu_a_in, alu_b_in));
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) req_op[i] = OP_ADD;

    // Reset state, with a request pending to prove req_ready is held low
    tick(); req_valid = 4'b0001; #1;
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_alu_in_valid", alu_in_valid, 1'b0);
    chk("rst_alu_op", alu_op_in, OP_ADD);
    chk("rst_alu_a", alu_a_in, 6'd0);
    chk("rst_alu_b", alu_b_in, 6'd0);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_rsp_data", rsp_data, 7'd0);
    chk("rst_outstanding", outstanding, 3'd0);
    chk("rst_err_orphan", err_orphan, 1'b0);
    tick(); req_valid = '0; rst = 1'b1;

    // Fairness: all four requesting for eight cycles
    tick(); req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = WIDTH'(i + 1);
      req_b[i] = WIDTH'(10 * i);
    end
    #1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        tick(); #1;
      end
`ifdef ALU_ARB_PRIO_EN
      fexp = 4'b0001;
`else
      fexp = 4'(1 << (k % 4));
`endif
      chk("fair_grant", req_ready, fexp);
    end
    tick(); req_valid = '0; #1;
`ifdef ALU_ARB_PRIO_EN
    chk("fair_last_issue_a", alu_a_in, 6'd1);
`else
    chk("fair_last_issue_a", alu_a_in, 6'd4);
`endif
    repeat (6) tick();
    #1;
    chk("fair_drain_outstanding", outstanding, 3'd0);
    chk("fair_drain_in_valid", alu_in_valid, 1'b0);

    // Single request: req0 ADD 5+7, ALU latency 2
    tick(); req_valid = 4'b0001; req_op[0] = OP_ADD; req_a[0] = 6'd5; req_b[0] = 6'd7; #1;
    chk("single_ready", req_ready, 4'b0001);
    tick(); req_valid = '0; #1;
    chk("single_in_valid", alu_in_valid, 1'b1);
    chk("single_a", alu_a_in, 6'd5);
    chk("single_b", alu_b_in, 6'd7);
    chk("single_op", alu_op_in, OP_ADD);
    chk("single_outstanding", outstanding, 3'd1);
    tick(); #1;
    chk("single_in_valid_drop", alu_in_valid, 1'b0);
    chk("single_no_rsp_early", rsp_valid, 4'b0000);
    tick(); #1;
    chk("single_rsp_not_yet", rsp_valid, 4'b0000);
    tick(); #1;
    chk("single_rsp_valid", rsp_valid, 4'b0001);
    chk("single_rsp_data", rsp_data, 7'd12);
    chk("single_outstanding_ret", outstanding, 3'd0);

    // Routing: req1 ADD 63+63 then req2 SUB 3-1
    tick(); req_valid = 4'b0110;
    req_op[1] = OP_ADD; req_a[1] = 6'd63; req_b[1] = 6'd63;
    req_op[2] = OP_SUB; req_a[2] = 6'd3;  req_b[2] = 6'd1;
    #1;
    chk("route_grant1", req_ready, 4'b0010);
    tick(); req_valid = 4'b0100; #1;
    chk("route_grant2", req_ready, 4'b0100);
    chk("route_issue1_a", alu_a_in, 6'd63);
    tick(); req_valid = '0; #1;
    chk("route_issue2_op", alu_op_in, OP_SUB);
    chk("route_issue2_a", alu_a_in, 6'd3);
    tick(); #1;
    chk("route_rsp_none", rsp_valid, 4'b0000);
    tick(); #1;
    chk("route_rsp1_valid", rsp_valid, 4'b0010);
    chk("route_rsp1_data", rsp_data, 7'd126);
    tick(); #1;
    chk("route_rsp2_valid", rsp_valid, 4'b0100);
    chk("route_rsp2_data", rsp_data, 7'd2);
    tick(); #1;
    chk("route_rsp_clear", rsp_valid, 4'b0000);
    chk("route_rsp_hold", rsp_data, 7'd2);
    chk("route_outstanding", outstanding, 3'd0);

    // Backpressure: ALU latency 10, requesters 1..3 always valid
    alu_lat = 10;
    tick(); req_valid = 4'b1110;
    for (int i = 1; i < NREQ; i++) begin
      req_op[i] = OP_ADD;
      req_a[i]  = WIDTH'(i);
      req_b[i]  = 6'd1;
    end
    #1;
    chk("bp_grant0", req_ready, 4'b1000);
    tick(); #1; chk("bp_grant1", req_ready, 4'b0010);
    tick(); #1; chk("bp_grant2", req_ready, 4'b0100);
    tick(); #1; chk("bp_grant3", req_ready, 4'b1000);
    for (int k = 4; k <= 10; k++) begin
      tick(); #1;
      chk("bp_stall_ready", req_ready, 4'b0000);
      chk("bp_stall_outstanding", outstanding, 3'd4);
    end
    tick(); #1;
    chk("bp_resume_ready", req_ready, 4'b0010);
    chk("bp_resume_outstanding", outstanding, 3'd4);
    tick(); #1;
    chk("bp_resume2_ready", req_ready, 4'b0100);
    chk("bp_resume2_outstanding", outstanding, 3'd4);
    tick(); req_valid = '0;
    repeat (12) tick();
    #1;
    chk("bp_drain_outstanding", outstanding, 3'd0);
    chk("bp_drain_rsp", rsp_valid, 4'b0000);

    // Orphan result with nothing in flight
    tick(); inj_valid = 1'b1; inj_data = 7'd5; #1;
    chk("orph_before", err_orphan, 1'b0);
    tick(); inj_valid = 1'b0; #1;
    chk("orph_set", err_orphan, 1'b1);
    chk("orph_no_rsp", rsp_valid, 4'b0000);
    chk("orph_outstanding", outstanding, 3'd0);
    repeat (3) tick();
    #1;
    chk("orph_sticky", err_orphan, 1'b1);

    // Reset with three operations in flight
    tick(); req_valid = 4'b0010; req_a[1] = 6'd9; req_b[1] = 6'd2; #1;
    chk("mid_grant0", req_ready, 4'b0010);
    tick(); #1; chk("mid_grant1", req_ready, 4'b0010);
    tick(); #1; chk("mid_grant2", req_ready, 4'b0010);
    tick(); req_valid = '0; #1;
    chk("mid_outstanding3", outstanding, 3'd3);
    chk("mid_in_valid_pre", alu_in_valid, 1'b1);
    rst = 1'b0;
    req_valid = 4'b1000; req_op[3] = OP_ADD; req_a[3] = 6'd20; req_b[3] = 6'd21;
    #1;
    chk("mid_rst_outstanding", outstanding, 3'd0);
    chk("mid_rst_in_valid", alu_in_valid, 1'b0);
    chk("mid_rst_a", alu_a_in, 6'd0);
    chk("mid_rst_rsp_data", rsp_data, 7'd0);
    chk("mid_rst_err_orphan", err_orphan, 1'b0);
    chk("mid_rst_ready", req_ready, 4'b0000);
    tick(); #1;
    chk("mid_rst_hold_ready", req_ready, 4'b0000);
    alu_lat = 1;
    tick(); rst = 1'b1; #1;
    chk("mid_post_grant3", req_ready, 4'b1000);
    tick(); req_valid = '0; #1;
    chk("mid_post_in_valid", alu_in_valid, 1'b1);
    chk("mid_post_a", alu_a_in, 6'd20);
    chk("mid_post_no_stale", rsp_valid, 4'b0000);
    tick(); #1;
    chk("mid_post_no_rsp_yet", rsp_valid, 4'b0000);
    tick(); #1;
    chk("mid_post_rsp_valid", rsp_valid, 4'b1000);
    chk("mid_post_rsp_data", rsp_data, 7'd41);
    chk("mid_post_outstanding", outstanding, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares a single ALU instance between `NREQ` requesters. It accepts operation requests on per-requester valid/ready channels and issues one operation per cycle to the ALU input port. It records the issuing requester in an in-order tag FIFO and steers each ALU result back to the requester that issued it. It sits between the requester blocks and the ALU, driving the ALU's `op_in`/`a_in`/`b_in`/`in_valid` and consuming its `out`/`out_valid`.

## Interface
- `WIDTH`, 6: operand width; results are `WIDTH+1` bits.
- `NREQ`, 4: number of requesters, 2..8.
- `MAX_OUT`, 4: maximum operations in flight in the ALU (tag FIFO depth), power of two, ≥2.

Ports:
- `clk`  in  1  clock, all logic on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_ready`  out  NREQ  request accepted this cycle (one-hot or zero).
- `req_op`  in  NREQ × `alu_types::operation_t`  per-requester opcode.
- `req_a`, `req_b`  in  NREQ × WIDTH  per-requester operands.
- `rsp_valid`  out  NREQ  result strobe, one-hot or zero, one cycle.
- `rsp_data`  out  WIDTH+1  result data, valid with any `rsp_valid` bit.
- `alu_op_in`  out  operation_t  to ALU `op_in`.
- `alu_a_in`, `alu_b_in`  out  WIDTH  to ALU `a_in`, `b_in`.
- `alu_in_valid`  out  1  to ALU `in_valid`.
- `alu_out`  in  WIDTH+1  from ALU `out`.
- `alu_out_valid`  in  1  from ALU `out_valid`.
- `outstanding`  out  $clog2(MAX_OUT)+1  operations issued but not yet returned.
- `err_orphan`  out  1  sticky: ALU result arrived with the tag FIFO empty.

## Operation
- ALU contract: exactly one `out_valid` pulse per accepted `in_valid`, in issue order, with no backpressure.
- Issue is allowed when `outstanding < MAX_OUT`, or when `outstanding == MAX_OUT` and `alu_out_valid` is high in the same cycle (retire frees a slot).
- Round-robin search:
  - The search starts at pointer `rr_ptr` and takes the first `req_valid[i]` at or after `rr_ptr`, wrapping at NREQ.
  - The winner gets `req_ready[i]=1`, which is combinational from `req_valid`, `rr_ptr` and slot availability.
  - On a grant, `rr_ptr <= (i+1) mod NREQ`. With no grant, `rr_ptr` holds.
- Issue register: on a grant, the next posedge loads `alu_op_in/alu_a_in/alu_b_in` from requester `i` and sets `alu_in_valid=1`. With no grant, `alu_in_valid=0` and the operand registers hold.
- Tag FIFO:
  - Pushes the index `i` on a grant.
  - Pops on `alu_out_valid`.
  - Push and pop in the same cycle are both performed.
  - `outstanding` = FIFO count and changes by +1, −1 or 0 per cycle.
- Response: on `alu_out_valid` with the FIFO non-empty, the next posedge sets `rsp_valid[head]=1` and `rsp_data=alu_out`. `rsp_data` holds its value otherwise.
- Orphan: on `alu_out_valid` with the FIFO empty, the result is dropped, `err_orphan` is set and stays set until reset, and no `rsp_valid` is raised.
- Requesters hold `req_valid` and their operands stable until `req_ready`. A requester may drop `req_valid` before it is granted; no ordering is implied by this.

## Timing
- Reset values (async assert, sync-to-clk deassert by the system):
  - `req_ready`=0 while in reset.
  - `alu_in_valid`=0, `alu_op_in`=0, `alu_a_in`=0, `alu_b_in`=0.
  - `rsp_valid`=0, `rsp_data`=0.
  - `outstanding`=0, `err_orphan`=0, `rr_ptr`=0, FIFO empty.
- Grant-to-ALU latency: `req_ready` in cycle N gives `alu_in_valid` in cycle N+1.
- Result-to-response latency: `alu_out_valid` in cycle M gives `rsp_valid` in cycle M+1.
- Sustained throughput is 1 issue per cycle when `MAX_OUT` ≥ ALU latency + 1. Otherwise issue stalls at `outstanding==MAX_OUT` until a retire.
- Reset mid-operation:
  - All in-flight tags are discarded and pending responses are lost.
  - The ALU shares `rst`, so no stale `out_valid` follows.
- A single requester holding `req_valid` is granted every cycle, subject to slot availability.

## Configuration
- `ALU_ARB_PRIO_EN` defined: requester 0 has fixed highest priority. When `req_valid[0]` is high and a slot is free, requester 0 wins regardless of `rr_ptr`, and `rr_ptr` is not updated. Requesters 1..NREQ-1 round-robin among themselves as above.
- `ALU_ARB_PRIO_EN` undefined: pure round-robin over all NREQ requesters.

## Test plan
- Single request: after reset, req0 sends ADD with a=5, b=7 → `req_ready[0]` in the same cycle, `alu_in_valid` with a=5, b=7 one cycle later, then `rsp_valid[0]` with `rsp_data`=12 one cycle after the ALU result.
- Fairness: all 4 `req_valid` held high for 8 cycles → grant order 0,1,2,3,0,1,2,3 (without `ALU_ARB_PRIO_EN`). With the macro → 0 every cycle.
- Backpressure: ALU stubbed with 10-cycle latency, `MAX_OUT`=4, continuous requests → exactly 4 issues, then `outstanding`=4 and `req_ready`=0 until the first `alu_out_valid`. Issue resumes in that same cycle.
- Routing: req1 ADD 63+63, req2 SUB 3−1 issued back-to-back → `rsp_valid[1]` with 126, then `rsp_valid[2]` with 2, in issue order.
- Orphan: `alu_out_valid` injected with `outstanding`=0 → `err_orphan`=1 and stays 1, no `rsp_valid`; cleared only by `rst`=0.
- Mid-flight reset: `rst` asserted with `outstanding`=3 → all outputs at reset values immediately. After release, a new request from req3 is granted first, since `rr_ptr`=0 and only req3 is valid.
